serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 97 +++++++++
 tb/tb_serial_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are latched on start and summed LSB first, one bit per clock,
// with the completed sum and final carry registered once all WIDTH bits have been processed.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_bit;
    logic             last_bit;
    logic             load;

    assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_bit  = (cnt == LAST);
    assign s_next    = (s_sr >> 1) | {sum_bit, {(WIDTH-1){1'b0}}};
    // A new operation may only be accepted when no bits are in flight.
    assign load      = start && (state != RUN);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (load) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_next;
            carry <= carry_bit;
            cnt   <= cnt + CW'(1);
            // Outputs only move on the edge that consumes the final bit.
            if (last_bit) begin
                Sum  <= s_next;
                Cout <= carry_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder; expected results are queued at issue time
// and a negedge monitor compares them whenever done is presented.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] hold_val;
    logic [WIDTH:0] pending;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .Sum   (sum),
        .Cout  (cout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'(0));
            end else begin
                check("result", 64'({cout, sum}), 64'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge; the start edge is the following posedge.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic [WIDTH:0] e);
        a = av;
        b = bv;
        cin = cv;
        start = 1'b1;
        exp_q.push_back(e);
        pending = e;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit scramble, input int inject_at);
        int busy_cnt = 0;
        int lat = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                check("held_result", 64'({cout, sum}), 64'(hold_val));
            end
            if (done) begin
                lat = j;
                break;
            end
            if (scramble) begin
                a = WIDTH'($urandom_range(0, 255));
                b = WIDTH'($urandom_range(0, 255));
                cin = 1'($urandom_range(0, 1));
            end
            if (j == inject_at) begin
                a = 8'hFF;
                b = 8'hFF;
                start = 1'b1;
            end else if (j == inject_at + 1) begin
                start = 1'b0;
            end
        end
        check("done_latency", 64'(lat), 64'(8));
        check("busy_cycles", 64'(busy_cnt), 64'(8));
        hold_val = pending;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH:0] e);
        issue(av, bv, cv, e);
        wait_done(1'b0, -1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        int n_done;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic cv;
        logic [WIDTH:0] e;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        hold_val = '0;
        pending = '0;

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_sum", 64'(sum), 64'(0));
        check("reset_cout", 64'(cout), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_start_idle", 64'(busy), 64'(0));

        run_op(8'h00, 8'h00, 1'b0, 9'h000);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100);
        run_op(8'hA5, 8'h5A, 1'b1, 9'h100);
        run_op(8'h3C, 8'h42, 1'b0, 9'h07E);

        // A start arriving mid-run must be ignored.
        issue(8'h10, 8'h20, 1'b0, 9'h030);
        wait_done(1'b0, 2);
        @(negedge clk);
        check("ignored_start_busy", 64'(busy), 64'(0));
        check("ignored_start_done", 64'(done), 64'(0));

        // Reset four cycles into a run, with start asserted during reset.
        a = 8'h55;
        b = 8'h22;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sum", 64'(sum), 64'(0));
        check("abort_cout", 64'(cout), 64'(0));
        rst_n = 1'b1;
        start = 1'b0;
        hold_val = '0;
        n_done = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("no_activity_after_abort", 64'(n_done), 64'(0));

        // Start held through DONE chains straight into the next run.
        issue(8'h3C, 8'h42, 1'b0, 9'h07E);
        wait_done(1'b0, -1);
        issue(8'h01, 8'h01, 1'b0, 9'h002);
        wait_done(1'b0, -1);
        @(negedge clk);
        check("chain_done_one_cycle", 64'(done), 64'(0));

        for (int i = 0; i < 256; i++) begin
            av = WIDTH'($urandom_range(0, 255));
            bv = WIDTH'($urandom_range(0, 255));
            cv = 1'($urandom_range(0, 1));
            e = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
            issue(av, bv, cv, e);
            wait_done(1'b1, -1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
